// File: rtl/sw_cond_pkg.sv
// sw_cond_pkg: shared state encoding, switch codes and helpers for the switch event conditioner
package sw_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REJECT = 2'd2
    } state_t;

    localparam logic [1:0] CODE_SW0 = 2'd0;
    localparam logic [1:0] CODE_SW1 = 2'd1;
    localparam logic [1:0] CODE_SW2 = 2'd2;
    localparam logic [1:0] CODE_SW3 = 2'd3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Only meaningful for a one-hot vector; anything else is filtered before use.
    function automatic logic [1:0] encode_sw(input logic [3:0] v);
        return v[1] ? CODE_SW1 : v[2] ? CODE_SW2 : v[3] ? CODE_SW3 : CODE_SW0;
    endfunction

endpackage

// File: rtl/sw_debouncer.sv
// sw_debouncer: 2-FF synchroniser plus whole-vector candidate/counter debouncer
module sw_debouncer
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int WIDTH           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_stable;

    // Synchronise the pins, then only publish a vector that stayed unchanged for the full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_cand;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/sw_event_conditioner.sv
// sw_event_conditioner: turns debounced switch presses into single-cycle coded events
module sw_event_conditioner
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20,
    parameter int CNT_EV_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          i_sw_raw,
    output logic [3:0]          o_sw_stable,
    output logic                o_event_valid,
    output logic [1:0]          o_event_code,
    output logic                o_error_multi,
    output logic                o_busy,
    output logic [CNT_EV_W-1:0] o_event_count
);

    logic [3:0]          w_sw_stable;
    state_t              r_state;
    state_t              w_state_next;
    logic                w_event;
    logic                w_error;
    logic                r_event_valid;
    logic [1:0]          r_event_code;
    logic                r_error_multi;
    logic                r_busy;
    logic [CNT_EV_W-1:0] r_event_count;

    sw_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .WIDTH           (4)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (i_sw_raw),
        .o_stable (w_sw_stable)
    );

    // Next state: events only fire leaving IDLE, so held or swapped switches never retrigger.
    always_comb begin
        w_state_next = r_state;
        w_event      = 1'b0;
        w_error      = 1'b0;
        case (r_state)
            IDLE: begin
                if (is_onehot(w_sw_stable)) begin
                    w_event      = 1'b1;
                    w_state_next = HELD;
                end else if (w_sw_stable != 4'd0) begin
                    w_error      = 1'b1;
                    w_state_next = REJECT;
                end
            end
            default: begin
                if (w_sw_stable == 4'd0) w_state_next = IDLE;
            end
        endcase
    end

    // State and registered strobes, code and event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_event_valid <= 1'b0;
            r_event_code  <= 2'd0;
            r_error_multi <= 1'b0;
            r_busy        <= 1'b0;
            r_event_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_event_valid <= w_event;
            r_event_code  <= w_event ? encode_sw(w_sw_stable) : 2'd0;
            r_error_multi <= w_error;
            r_busy        <= (w_state_next != IDLE);
            r_event_count <= r_event_count + CNT_EV_W'(w_event);
        end
    end

    assign o_sw_stable   = w_sw_stable;
    assign o_event_valid = r_event_valid;
    assign o_event_code  = r_event_code;
    assign o_error_multi = r_error_multi;
    assign o_busy        = r_busy;
    assign o_event_count = r_event_count;

endmodule

// File: tb/tb_sw_event_conditioner.sv
// tb_sw_event_conditioner: directed table-driven checks of the switch event conditioner
module tb_sw_event_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] i_sw_raw;
    logic [3:0] o_sw_stable;
    logic       o_event_valid;
    logic [1:0] o_event_code;
    logic       o_error_multi;
    logic       o_busy;
    logic [7:0] o_event_count;

    int checks = 0;
    int failures = 0;
    int ev_total = 0;
    int err_total = 0;
    logic [1:0] last_code = 2'd0;
    int exp_count = 0;

    typedef struct {
        logic [3:0] raw;
        int         hold;
        int         rel;
        int         ev;
        logic [1:0] code;
        int         err;
        logic [3:0] stable;
        logic       busy;
    } vec_t;

    vec_t tbl[11];

    sw_event_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .CNT_EV_W        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_sw_raw      (i_sw_raw),
        .o_sw_stable   (o_sw_stable),
        .o_event_valid (o_event_valid),
        .o_event_code  (o_event_code),
        .o_error_multi (o_error_multi),
        .o_busy        (o_busy),
        .o_event_count (o_event_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (o_event_valid) begin
            ev_total++;
            last_code = o_event_code;
        end
        if (o_error_multi) err_total++;
        checks++;
        if ((o_event_valid && o_error_multi) || (!o_event_valid && o_event_code != 2'd0)) begin
            failures++;
            $display("FAIL strobe_exclusive valid=%0b err=%0b code=%0h at %0t", o_event_valid, o_error_multi, o_event_code, $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] raw, input int n);
        i_sw_raw = raw;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stable"}, 32'(o_sw_stable), 0);
        check({tag, "_valid"}, 32'(o_event_valid), 0);
        check({tag, "_code"}, 32'(o_event_code), 0);
        check({tag, "_err"}, 32'(o_error_multi), 0);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_count"}, 32'(o_event_count), 0);
    endtask

    initial begin
        int ev0, er0, hit;
        tbl[0]  = '{4'b0010, 12, 12, 1, 2'd1, 0, 4'b0010, 1'b1};
        tbl[1]  = '{4'b0100, 12, 12, 1, 2'd2, 0, 4'b0100, 1'b1};
        tbl[2]  = '{4'b1000, 12, 12, 1, 2'd3, 0, 4'b1000, 1'b1};
        tbl[3]  = '{4'b0100,  4, 12, 0, 2'd0, 0, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0011, 12, 12, 0, 2'd0, 1, 4'b0011, 1'b1};
        tbl[5]  = '{4'b0100, 12, 12, 1, 2'd2, 0, 4'b0100, 1'b1};
        tbl[6]  = '{4'b0001, 12,  0, 1, 2'd0, 0, 4'b0001, 1'b1};
        tbl[7]  = '{4'b1001, 12, 12, 0, 2'd0, 0, 4'b1001, 1'b1};
        tbl[8]  = '{4'b1000, 12, 12, 1, 2'd3, 0, 4'b1000, 1'b1};
        tbl[9]  = '{4'b0001, 12,  0, 1, 2'd0, 0, 4'b0001, 1'b1};
        tbl[10] = '{4'b0010, 12, 12, 0, 2'd0, 0, 4'b0010, 1'b1};

        reset = 1'b1;
        i_sw_raw = 4'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        ev0 = ev_total;
        i_sw_raw = 4'b0001;
        for (int e = 0; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) check("t1_stable_k5", 32'(o_sw_stable), 0);
            if (e == 6) check("t1_stable_k6", 32'(o_sw_stable), 1);
            if (e == 6) check("t1_valid_k6", 32'(o_event_valid), 0);
            if (e == 7) check("t1_valid_k7", 32'(o_event_valid), 1);
            if (e == 7) check("t1_code_k7", 32'(o_event_code), 0);
            if (e == 7) check("t1_busy_k7", 32'(o_busy), 1);
            if (e == 8) check("t1_valid_k8", 32'(o_event_valid), 0);
        end
        @(negedge clk);
        drive(4'b0001, 11);
        exp_count = 1;
        check("t1_events", 32'(ev_total - ev0), 1);
        check("t1_count", 32'(o_event_count), 32'(exp_count));
        check("t1_busy_held", 32'(o_busy), 1);
        drive(4'b0000, 12);
        check("t1_busy_rel", 32'(o_busy), 0);

        for (int i = 0; i < 11; i++) begin
            ev0 = ev_total;
            er0 = err_total;
            drive(tbl[i].raw, tbl[i].hold);
            check($sformatf("row%0d_stable", i), 32'(o_sw_stable), 32'(tbl[i].stable));
            check($sformatf("row%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
            if (tbl[i].rel > 0) begin
                drive(4'b0000, tbl[i].rel);
                check($sformatf("row%0d_rel_stable", i), 32'(o_sw_stable), 0);
                check($sformatf("row%0d_rel_busy", i), 32'(o_busy), 0);
            end
            exp_count = (exp_count + tbl[i].ev) % 256;
            check($sformatf("row%0d_events", i), 32'(ev_total - ev0), 32'(tbl[i].ev));
            check($sformatf("row%0d_errors", i), 32'(err_total - er0), 32'(tbl[i].err));
            check($sformatf("row%0d_count", i), 32'(o_event_count), 32'(exp_count));
            if (tbl[i].ev > 0) check($sformatf("row%0d_code", i), 32'(last_code), 32'(tbl[i].code));
        end

        reset = 1'b1;
        drive(4'b0000, 2);
        reset = 1'b0;
        exp_count = 0;
        ev0 = ev_total;
        for (int i = 0; i < 256; i++) begin
            drive(4'b0001, 10);
            drive(4'b0000, 10);
            if (i == 254) check("wrap_count_255", 32'(o_event_count), 255);
        end
        check("wrap_events", 32'(ev_total - ev0), 256);
        check("wrap_count_0", 32'(o_event_count), 0);

        drive(4'b0100, 12);
        check("mid_busy_before", 32'(o_busy), 1);
        drive(4'b0010, 3);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        reset = 1'b0;
        ev0 = ev_total;
        hit = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (o_event_valid && hit == 0) hit = n;
        end
        @(negedge clk);
        check("midrst_event_edge", 32'(hit), 8);
        check("midrst_events", 32'(ev_total - ev0), 1);
        check("midrst_code", 32'(last_code), 1);
        check("midrst_count", 32'(o_event_count), 1);
        drive(4'b0000, 12);
        check("final_busy", 32'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
